// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters and
// resolved-branch / misprediction statistics. Lookup is combinational.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int PC_W      = 64,
    parameter int TAG_W     = 10,
    parameter int CNT_W     = 32,
    parameter int PRED_MODE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic             flush_all,
    output logic [CNT_W-1:0] stat_updates,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    logic [PC_W-1:0]    target_reg [ENTRIES];
    logic [1:0]         ctr_reg    [ENTRIES];

    logic [CNT_W-1:0]   stat_updates_reg;
    logic [CNT_W-1:0]   stat_mispredicts_reg;

    logic [IDX_W-1:0]   lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    logic               lookup_match;

    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_hit;
    logic [1:0]         upd_ctr;
    logic [1:0]         ctr_next;
    logic [ENTRIES-1:0] upd_sel;
    logic               upd_mispredict;
    logic               unused_bits;

    // Only the index and tag fields of the update PC participate.
    assign unused_bits = ^upd_pc;

    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign lookup_tag = lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign upd_tag    = upd_pc[IDX_W+1+TAG_W:IDX_W+2];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_sel
        assign upd_sel[gi] = (upd_idx == IDX_W'(gi));
    end

    // Outputs are gated by reset so the table contents are irrelevant while it is held.
    assign lookup_match = reset && valid_reg[lookup_idx] &&
                          (tag_reg[lookup_idx] == lookup_tag);

    always_comb begin
        pred_hit    = lookup_match;
        pred_taken  = 1'b0;
        pred_target = lookup_pc + PC_W'(4);
        if (lookup_match) begin
            pred_target = target_reg[lookup_idx];
            if (PRED_MODE == 1) begin
                pred_taken = ctr_reg[lookup_idx][1];
            end
        end
    end

    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
    assign upd_ctr = ctr_reg[upd_idx];

    always_comb begin
        ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != 2'b11) begin
                ctr_next = upd_ctr + 2'b01;
            end
        end else begin
            if (upd_ctr != 2'b00) begin
                ctr_next = upd_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_reg[i] <= 2'b01;
            end
        end else if (flush_all) begin
            valid_reg <= '0;
        end else if (upd_valid) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (upd_sel[i]) begin
                    if (upd_hit) begin
                        ctr_reg[i] <= ctr_next;
                        if (upd_taken) begin
                            target_reg[i] <= upd_target;
                        end
                    end else if (upd_taken) begin
                        // Allocation evicts whatever occupied this slot.
                        valid_reg[i]  <= 1'b1;
                        tag_reg[i]    <= upd_tag;
                        target_reg[i] <= upd_target;
                        ctr_reg[i]    <= 2'b10;
                    end
                end
            end
        end
    end

    assign upd_mispredict = upd_taken != upd_pred_taken;

    // Statistics keep counting through a flush; they saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (upd_valid) begin
            if (stat_updates_reg != '1) begin
                stat_updates_reg <= stat_updates_reg + CNT_W'(1);
            end
            if (upd_mispredict && (stat_mispredicts_reg != '1)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + CNT_W'(1);
            end
        end
    end

    assign stat_updates     = stat_updates_reg;
    assign stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: default predictor plus a static-mode, 4-bit-statistics copy
// sharing the same stimulus.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [63:0] lookup_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        upd_pred_taken;
    logic        flush_all;

    logic        pred_hit, pred_taken;
    logic [63:0] pred_target;
    logic [31:0] stat_updates, stat_mispredicts;

    logic        s_hit, s_taken;
    logic [63:0] s_target;
    logic [3:0]  s_updates, s_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_upd  = 0;
    int exp_mis  = 0;

    branch_predictor dut (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .flush_all(flush_all),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor #(.CNT_W(4), .PRED_MODE(0)) dut_s (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .flush_all(flush_all),
        .stat_updates(s_updates), .stat_mispredicts(s_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [63:0] pc);
        lookup_pc = pc;
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                       input logic ptk);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = ptk;
        tick();
        exp_upd++;
        if (tk != ptk) exp_mis++;
        upd_valid      = 1'b0;
        upd_pc         = 'x;
        upd_taken      = 1'bx;
        upd_target     = 'x;
        upd_pred_taken = 1'bx;
        $display("upd pc=0x%0h taken=%0b target=0x%0h pred=%0b", pc, tk, tgt, ptk);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_upd"},   64'(stat_updates),     64'(exp_upd));
        chk({tag, "_mis"},   64'(stat_mispredicts), 64'(exp_mis));
        chk({tag, "_s_upd"}, 64'(s_updates),        64'(exp_upd > 15 ? 15 : exp_upd));
        chk({tag, "_s_mis"}, 64'(s_mispredicts),    64'(exp_mis > 15 ? 15 : exp_mis));
    endtask

    initial begin
        reset = 1'b0; flush_all = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        lookup_pc = 64'h100;
        #1;
        chk("in_reset_hit",    64'(pred_hit),   64'd0);
        chk("in_reset_target", pred_target,     64'h104);
        tick(); tick();
        chk("in_reset_taken",  64'(pred_taken), 64'd0);
        chk_stats("reset");
        reset = 1'b1;
        tick();

        look(64'h100);
        chk("idle_hit",    64'(pred_hit),   64'd0);
        chk("idle_taken",  64'(pred_taken), 64'd0);
        chk("idle_target", pred_target,     64'h104);

        upd(64'h100, 1'b1, 64'h80, 1'b0);
        look(64'h100);
        chk("alloc_hit",     64'(pred_hit),   64'd1);
        chk("alloc_taken",   64'(pred_taken), 64'd1);
        chk("alloc_target",  pred_target,     64'h80);
        chk("static_hit",    64'(s_hit),      64'd1);
        chk("static_taken",  64'(s_taken),    64'd0);
        chk("static_target", s_target,        64'h80);
        chk_stats("alloc");

        upd(64'h100, 1'b0, 64'hdead, 1'b1);
        look(64'h100);
        chk("nt1_hit",   64'(pred_hit),   64'd1);
        chk("nt1_taken", 64'(pred_taken), 64'd0);
        for (int k = 2; k <= 4; k++) begin
            upd(64'h100, 1'b0, 64'hdead, 1'b0);
            look(64'h100);
            chk($sformatf("nt%0d_taken", k), 64'(pred_taken), 64'd0);
        end
        chk("nt_keep_target", pred_target, 64'h80);

        // Counter sits at 0: one taken step must not yet predict taken.
        upd(64'h100, 1'b1, 64'h90, 1'b0);
        look(64'h100);
        chk("t1_taken",  64'(pred_taken), 64'd0);
        chk("t1_target", pred_target,     64'h90);
        upd(64'h100, 1'b1, 64'h90, 1'b0);
        look(64'h100);
        chk("t2_taken", 64'(pred_taken), 64'd1);
        upd(64'h100, 1'b1, 64'h90, 1'b1);
        upd(64'h100, 1'b1, 64'h90, 1'b1);
        upd(64'h100, 1'b0, 64'h90, 1'b1);
        look(64'h100);
        chk("sat3_dec_taken", 64'(pred_taken), 64'd1);
        chk_stats("train");

        upd(64'h140, 1'b1, 64'h200, 1'b0);
        look(64'h100);
        chk("evict_old_hit",    64'(pred_hit), 64'd0);
        chk("evict_old_target", pred_target,   64'h104);
        look(64'h140);
        chk("evict_new_hit",    64'(pred_hit), 64'd1);
        chk("evict_new_target", pred_target,   64'h200);

        upd(64'h204, 1'b0, 64'h500, 1'b0);
        look(64'h204);
        chk("nt_miss_noalloc", 64'(pred_hit), 64'd0);

        upd(64'h108, 1'b1, 64'h300, 1'b1);
        look(64'h10b);
        chk("lowbits_hit",    64'(pred_hit), 64'd1);
        chk("lowbits_target", pred_target,   64'h300);

        flush_all = 1'b1;
        upd(64'h20c, 1'b1, 64'h400, 1'b0);
        flush_all = 1'b0;
        look(64'h20c);
        chk("flush_alloc_hit", 64'(pred_hit), 64'd0);
        look(64'h140);
        chk("flush_140_hit", 64'(pred_hit), 64'd0);
        look(64'h108);
        chk("flush_108_hit", 64'(pred_hit), 64'd0);
        chk_stats("flush");

        upd(64'h108, 1'b1, 64'h300, 1'b1);
        tick(); tick();
        look(64'h108);
        chk("idle_x_hit", 64'(pred_hit), 64'd1);
        chk_stats("idle_x");

        for (int k = 0; k < 20; k++) begin
            upd(64'h3f0, 1'b0, 64'h0, 1'b1);
        end
        chk_stats("saturate");
        chk("sat_s_upd_15", 64'(s_updates), 64'd15);

        // Reset overrides a simultaneous allocating update.
        reset     = 1'b0;
        upd_valid = 1'b1; upd_pc = 64'h100; upd_taken = 1'b1;
        upd_target = 64'h88; upd_pred_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        exp_upd = 0; exp_mis = 0;
        chk_stats("midreset");
        reset = 1'b1;
        tick();
        look(64'h100);
        chk("midreset_hit_100", 64'(pred_hit), 64'd0);
        look(64'h108);
        chk("midreset_hit_108", 64'(pred_hit), 64'd0);
        chk("midreset_target",  pred_target,   64'h10c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameters SHALL be, one per line:
- ENTRIES, default 16, BTB entry count; power of 2, minimum 2; IDX_W = log2(ENTRIES).
- PC_W, default 64, PC/target width.
- TAG_W, default 10, stored tag width.
- CNT_W, default 32, statistics counter width.
- PRED_MODE, default 1; 0 = static not-taken, 1 = 2-bit dynamic.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous active-low reset.
- lookup_pc, in, PC_W, IF-stage PC.
- pred_hit, out, 1, valid entry with matching tag.
- pred_taken, out, 1, predict taken.
- pred_target, out, PC_W, predicted target.
- upd_valid, in, 1, a branch resolved this cycle.
- upd_pc, in, PC_W, PC of the resolved branch.
- upd_taken, in, 1, actual outcome.
- upd_target, in, PC_W, actual target (pc+imm).
- upd_pred_taken, in, 1, prediction that was made for this branch.
- flush_all, in, 1, invalidate the whole table.
- stat_updates, out, CNT_W, resolved-branch count.
- stat_mispredicts, out, CNT_W, misprediction count.

REQ-003 The reset port SHALL be named reset, SHALL be synchronous and active-low (reset==0 at a rising clk edge resets), with one clock domain clk.

Function
REQ-004 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+1+TAG_W:IDX_W+2]; pc[1:0] SHALL be ignored.
REQ-005 Each entry SHALL hold valid (1b), tag (TAG_W), target (PC_W), ctr (2b saturating).
REQ-006 Lookup SHALL be combinational from registered table state, with zero-cycle latency.
REQ-007 pred_hit SHALL be 1 iff the entry at the index is valid and its tag equals the lookup tag.
REQ-008 PRED_MODE=1: pred_taken SHALL equal pred_hit AND ctr[1]; PRED_MODE=0: pred_taken SHALL be 0.
REQ-009 pred_target SHALL be the entry target when pred_hit=1, else lookup_pc+4 (mod 2^PC_W).
REQ-010 Update SHALL occur at the clk edge when upd_valid=1 and flush_all=0, with one-cycle latency: visible to lookup the following cycle.
REQ-011 Update hit: ctr SHALL increment when taken (saturating at 3) and decrement when not taken (saturating at 0); target SHALL be overwritten only when taken.
REQ-012 Update miss with upd_taken=1 SHALL allocate: valid=1, new tag, target=upd_target, ctr=2'b10, replacing any prior occupant.
REQ-013 Update miss with upd_taken=0 SHALL leave the table unchanged.
REQ-014 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update state (no bypass).
REQ-015 flush_all=1 SHALL clear every valid bit at the edge; it SHALL win over a simultaneous update to the table; ctr/target/tag contents are don't-care.
REQ-016 stat_updates SHALL increment on each edge with upd_valid=1, including during flush_all=1.
REQ-017 stat_mispredicts SHALL increment when upd_valid=1 and upd_taken != upd_pred_taken.
REQ-018 Both statistics counters SHALL saturate at 2^CNT_W-1, never wrapping.
REQ-019 PRED_MODE=0 SHALL still maintain the table and statistics; only pred_taken is forced to 0.
REQ-020 Unknown (X) upd_* inputs while upd_valid=0 SHALL not alter state.

Reset
REQ-021 At a clk edge with reset=0: all valid bits SHALL be 0, all ctr SHALL be 2'b01, and stat_updates and stat_mispredicts SHALL be 0; reset SHALL override update and flush.
REQ-022 During and after reset, outputs SHALL be pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
REQ-023 Reset asserted mid-sequence SHALL discard all learned state within the same edge.

Verification
REQ-024 After reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-025 Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> next cycle lookup 0x100 gives hit=1, taken=1, target=0x80; stat_updates=1, stat_mispredicts=1.
REQ-026 Four not-taken updates of 0x100 after allocate -> ctr steps 2,1,0,0 (saturates); taken=0 from the first decrement onward.
REQ-027 ENTRIES=16: allocate 0x100, then allocate 0x140 (same index, different tag) -> lookup 0x100 hit=0, lookup 0x140 hit=1.
REQ-028 Same-cycle flush_all=1 and allocating update -> next cycle hit=0 for that PC; stat_updates still increments.
REQ-029 CNT_W=4 with 20 mispredicting updates -> both stats read 15 (saturated).
